// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
//   Shared definitions for the async FIFO read/write controllers:
//     - pointer-width limits and parameter bounds
//     - rd_mode_e : read-port mode (standard / first-word-fall-through)
//     - bin2gray / gray2bin : pointer code conversion
//   The conversion functions work on a PTR_MAX_W-wide vector. Callers
//   zero-extend a narrower pointer into them and truncate the result back.
//   Both conversions are exact under zero extension, so one function pair
//   serves every pointer width up to PTR_MAX_W.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int MIN_DEPTH = 4;
    localparam int MIN_SYNC  = 2;
    localparam int MAX_SYNC  = 4;
    localparam int PTR_MAX_W = 32;

    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    // Binary -> Gray: adjacent codes differ in one bit.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above
    // it. The prefix-XOR is built in log2(PTR_MAX_W) doubling steps.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin = gray;
        for (int sh = 1; sh < PTR_MAX_W; sh = sh * 2) begin
            bin = bin ^ (bin >> sh);
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_gray_sync.sv
// -----------------------------------------------------------------------------
// cdc_gray_sync
//   Multi-flop synchroniser for a Gray-coded pointer. The pointer enters from
//   another clock domain and is carried into the rd_clk domain. Only one bit
//   changes per pointer step, so every synchronised sample is either the old
//   value or the new value. It is never a mix of the two.
//
// Parameters
//   STAGES : number of flops in the chain (MIN_SYNC..MAX_SYNC)
//   WIDTH  : pointer width
//
// Ports
//   rd_clk : destination clock
//   rst    : synchronous, active-high reset. It clears the whole chain.
//   d      : Gray pointer from the foreign domain (asynchronous to rd_clk)
//   q      : synchronised Gray pointer (output of the last stage)
// -----------------------------------------------------------------------------
module cdc_gray_sync
    import async_fifo_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int WIDTH  = 5
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < MIN_SYNC || STAGES > MAX_SYNC) begin : g_bad_stages
        $error("cdc_gray_sync: STAGES must be in %0d..%0d", MIN_SYNC, MAX_SYNC);
    end

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

    // NOTE: sequential state is written with non-blocking assignments only.
    // Each stage therefore samples the previous stage's old value, which is
    // what turns this loop into a shift chain rather than a single wire.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            // NOTE: this array is a flop chain, not a RAM. It is reset
            // element by element so that a stale foreign pointer cannot leak
            // out after reset. A real memory array would not be reset this way.
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_port.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_port
//   Read-domain half of the async FIFO. It does the following:
//     - brings the write-side Gray pointer into rd_clk
//     - owns the read pointer
//     - drives the shared RAM read port
//     - reports empty, occupancy and almost-empty as seen from the read side
//
//   Two read modes:
//     FWFT=0 : standard. Data appears in the RAM output register one cycle
//              after an accepted rd_en (dout_valid pulses).
//     FWFT=1 : first-word-fall-through. The head word is prefetched into the
//              RAM output register, and rd_en pops it.
//
// Build option
//   ASYNC_RD_UNDERFLOW_EN : when defined, underflow is a sticky flag. It is set
//   the cycle after rd_en arrives while empty, and cleared only by rst. When
//   undefined, underflow is tied low and no flop is built.
//
// Parameters
//   DEPTH       : entries, power of 2, >= MIN_DEPTH (AW = log2(DEPTH))
//   SYNC_STAGES : flops on the wr_ptr_gray crossing (2..4)
//   FWFT        : 0 standard, 1 first-word-fall-through
//   AE_THRESH   : almost_empty when rd_count <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   rd_clk       : read clock
//   rst          : synchronous, active-high reset (rd_clk domain)
//   wr_ptr_gray  : write pointer, Gray, wr_clk domain
//   rd_en        : read request (standard) / pop head word (FWFT)
//   rd_ptr_gray  : registered Gray read pointer, to the write-side synchroniser
//   mem_rd_en    : RAM read enable
//   mem_rd_addr  : RAM read address
//   dout_valid   : RAM output register holds valid FIFO data
//   empty        : no word readable
//   almost_empty : registered, rd_count <= AE_THRESH
//   rd_count     : registered occupancy, 0..DEPTH
//   underflow    : sticky read-while-empty flag (see build option)
// -----------------------------------------------------------------------------
module async_fifo_rd_port
    import async_fifo_pkg::*;
#(
    parameter  int DEPTH       = 16,
    parameter  int SYNC_STAGES = 2,
    parameter  int FWFT        = 0,
    parameter  int AE_THRESH   = 1,
    localparam int AW          = $clog2(DEPTH),
    localparam int PW          = AW + 1
) (
    input  logic          rd_clk,
    input  logic          rst,
    input  logic [PW-1:0] wr_ptr_gray,
    input  logic          rd_en,
    output logic [PW-1:0] rd_ptr_gray,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    output logic          dout_valid,
    output logic          empty,
    output logic          almost_empty,
    output logic [PW-1:0] rd_count,
    output logic          underflow
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (DEPTH < MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("async_fifo_rd_port: DEPTH (%0d) must be a power of 2 >= %0d", DEPTH, MIN_DEPTH);
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("async_fifo_rd_port: AE_THRESH (%0d) must be in 0..DEPTH-1", AE_THRESH);
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("async_fifo_rd_port: FWFT must be 0 or 1");
    end

    localparam rd_mode_e      MODE     = rd_mode_e'(FWFT != 0);
    localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

    // ------------------------------------------------------------------
    // Write-pointer crossing and occupancy
    // ------------------------------------------------------------------
    logic [PW-1:0] wsync_gray;
    logic [PW-1:0] wsync_bin;
    logic [PW-1:0] rd_ptr_bin;
    logic [PW-1:0] rd_ptr_bin_next;
    logic [PW-1:0] mem_cnt;
    logic          mem_empty;

    cdc_gray_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (PW)
    ) u_wptr_sync (
        .rd_clk (rd_clk),
        .rst    (rst),
        .d      (wr_ptr_gray),
        .q      (wsync_gray)
    );

    assign wsync_bin = PW'(gray2bin(PTR_MAX_W'(wsync_gray)));

    // Pointers run over 2*DEPTH. The PW-bit subtraction wraps modulo 2^PW,
    // so the difference is the true word count from 0 to DEPTH. The MSB is
    // what separates full (count DEPTH) from empty (count 0).
    assign mem_cnt         = wsync_bin - rd_ptr_bin;
    assign mem_empty       = (mem_cnt == '0);
    assign rd_ptr_bin_next = rd_ptr_bin + PW'(1);
    assign mem_rd_addr     = rd_ptr_bin[AW-1:0];

    // ------------------------------------------------------------------
    // Mode-dependent read control
    // ------------------------------------------------------------------
    logic          dout_valid_next;
    logic [PW-1:0] rd_count_next;

    // NOTE: every signal driven here gets a default before any branch.
    // A path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        mem_rd_en       = 1'b0;
        empty           = 1'b1;
        dout_valid_next = 1'b0;
        rd_count_next   = mem_cnt;
        if (!rst) begin
            unique case (MODE)
                RD_STD: begin
                    mem_rd_en       = rd_en & ~mem_empty;
                    empty           = mem_empty;
                    dout_valid_next = mem_rd_en;
                    rd_count_next   = mem_cnt;
                end
                RD_FWFT: begin
                    // Refill the output register whenever it is free, or
                    // when its word is popped this cycle. That sustains one
                    // word per cycle under continuous rd_en.
                    mem_rd_en       = ~mem_empty & (~dout_valid | rd_en);
                    empty           = ~dout_valid;
                    dout_valid_next = mem_rd_en | (dout_valid & ~rd_en);
                    // The prefetched head word has left the RAM but is still
                    // unread, so it counts toward occupancy.
                    rd_count_next   = mem_cnt + PW'(dout_valid);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read pointer, data-valid, occupancy and almost-empty
    // ------------------------------------------------------------------
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            rd_ptr_bin   <= '0;
            rd_ptr_gray  <= '0;
            dout_valid   <= 1'b0;
            rd_count     <= '0;
            almost_empty <= 1'b1;
        end else begin
            if (mem_rd_en) begin
                rd_ptr_bin  <= rd_ptr_bin_next;
                // Gray is encoded from the next binary value, so the
                // exported pointer is a clean flop output with no logic in
                // front of the write-side synchroniser.
                rd_ptr_gray <= PW'(bin2gray(PTR_MAX_W'(rd_ptr_bin_next)));
            end
            dout_valid   <= dout_valid_next;
            rd_count     <= rd_count_next;
            // Compared against the registered count, so the flag trails
            // rd_count by one cycle.
            almost_empty <= (rd_count <= AE_LIMIT);
        end
    end

    // ------------------------------------------------------------------
    // Underflow flag
    // ------------------------------------------------------------------
`ifdef ASYNC_RD_UNDERFLOW_EN
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (rd_en && empty) begin
            underflow <= 1'b1;
        end
    end
`else
    assign underflow = 1'b0;
`endif

endmodule
